sipo_deser: RTL and testbench

- Serial-in/parallel-out deserializer; receive end of the 4-bit parallel-to-serial shifter link.
- Samples one serial bit per qualified clock and assembles WIDTH-bit words.
- Presents each completed word on a valid/ready output register, with overrun detection.
- Sits between the serial line and the downstream parallel consumer.

---
 rtl/sipo_deser.sv | 121 ++++++++++++
 tb/tb_sipo_deser.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deser
//  Description : Serial-in/parallel-out deserializer. Samples one qualified
//                serial bit per clock, assembles WIDTH-bit words and presents
//                them on a valid/ready output register with sticky overrun.
//                Optional macro SIPO_PARITY_EN appends one even-parity bit per
//                frame and adds the parity_err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
`ifdef SIPO_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    // Frame length in bit slots; the parity build adds one trailing slot.
`ifdef SIPO_PARITY_EN
    localparam int c_FRAME = WIDTH + 1;
`else
    localparam int c_FRAME = WIDTH;
`endif
    localparam int c_CW = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_FRAME - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [WIDTH-1:0] r_sh;
    logic [c_CW-1:0]  r_cnt;

    logic [c_CW-1:0]  w_cnt_eff;
    logic [c_CW-1:0]  w_cnt_next;
    logic             w_last;
    logic [WIDTH-1:0] w_sh_next;

`ifdef SIPO_PARITY_EN
    localparam logic [c_CW-1:0] c_WIDTH_CW = c_CW'(WIDTH);
    logic r_par;
    logic w_par_next;
`endif

    // Next-state of the shifter and bit counter for a qualified bit.
    always_comb begin
        // A start-of-frame bit is always slot 0, abandoning any partial word.
        w_cnt_eff  = sof ? '0 : r_cnt;
        w_last     = (w_cnt_eff == c_LAST);
        w_cnt_next = w_last ? '0 : (w_cnt_eff + c_ONE);
        w_sh_next  = r_sh;
`ifdef SIPO_PARITY_EN
        // The parity slot does not enter the data shifter.
        if (w_cnt_eff < c_WIDTH_CW) begin
`else
        begin
`endif
            if (MSB_FIRST) begin
                w_sh_next = {r_sh[WIDTH-2:0], sin};
            end else begin
                w_sh_next = {sin, r_sh[WIDTH-1:1]};
            end
        end
`ifdef SIPO_PARITY_EN
        // Running XOR over data and parity bits; restarts at slot 0.
        w_par_next = (w_cnt_eff == '0) ? sin : (r_par ^ sin);
`endif
    end

    // Capture, word completion, output handshake and overrun tracking.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_sh       <= '0;
            r_cnt      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_par      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (sin_en) begin
                r_sh  <= w_sh_next;
                r_cnt <= w_cnt_next;
                busy  <= (w_cnt_next != '0);
`ifdef SIPO_PARITY_EN
                r_par <= w_par_next;
`endif
                if (w_last) begin
                    // Load only if the output register is free or being
                    // drained on this same edge; otherwise drop and flag.
                    if (!dout_valid || dout_ready) begin
                        dout       <= w_sh_next;
                        dout_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                        parity_err <= w_par_next;
`endif
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_deser
//  Description : Directed self-checking bench for sipo_deser (WIDTH=4).
//                dut0 is LSB-first, dut1 is MSB-first; both share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       sin = 1'b0;
    logic       sin_en = 1'b0;
    logic       sof = 1'b0;
    logic       dout_ready = 1'b0;

    logic [3:0] dout0, dout1;
    logic       valid0, valid1;
    logic       busy0, busy1;
    logic       ovr0, ovr1;
`ifdef SIPO_PARITY_EN
    logic       perr0, perr1;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .clr(clr), .sin(sin), .sin_en(sin_en), .sof(sof),
        .dout(dout0), .dout_valid(valid0), .dout_ready(dout_ready),
        .busy(busy0),
`ifdef SIPO_PARITY_EN
        .parity_err(perr0),
`endif
        .overrun(ovr0)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .clr(clr), .sin(sin), .sin_en(sin_en), .sof(sof),
        .dout(dout1), .dout_valid(valid1), .dout_ready(dout_ready),
        .busy(busy1),
`ifdef SIPO_PARITY_EN
        .parity_err(perr1),
`endif
        .overrun(ovr1)
    );

    // One clock edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        sin = b; sin_en = 1'b1; sof = s;
        step();
        sin_en = 1'b0; sof = 1'b0; sin = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        sin = 1'b1; sin_en = 1'b1; sof = 1'b1; dout_ready = 1'b1;
        do_reset();
        sin_en = 1'b0; sof = 1'b0; sin = 1'b0;
        checks++; if (dout0 !== 4'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout0); end
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", ovr0); end
        checks++; if (dout1 !== 4'h0 || valid1 !== 1'b0) begin failures++; $display("FAIL reset_dut1 got dout=%h valid=%b exp dout=0 valid=0", dout1, valid1); end
    endtask

    task automatic test_lsb_word();
        logic [3:0] bits;
        logic [3:0] exp_busy;
        bits = 4'b1101;       // sent b0 first: 1,0,1,1
        exp_busy = 4'b0111;   // busy after edges 1..4 = 1,1,1,0 (index = edge-1)
        dout_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_bit(bits[i], 1'b0);
            checks++;
            if (busy0 !== exp_busy[i]) begin
                failures++; $display("FAIL lsb_busy_edge%0d got=%b exp=%b", i + 1, busy0, exp_busy[i]);
            end
            if (i < 3) begin
                checks++;
                if (valid0 !== 1'b0) begin failures++; $display("FAIL lsb_early_valid edge%0d got=%b exp=0", i + 1, valid0); end
            end
        end
        checks++; if (valid0 !== 1'b1) begin failures++; $display("FAIL lsb_valid got=%b exp=1", valid0); end
        checks++; if (dout0 !== 4'hD) begin failures++; $display("FAIL lsb_dout got=%h exp=d", dout0); end
        step();
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL lsb_valid_one_cycle got=%b exp=0", valid0); end
    endtask

    task automatic test_msb_gaps();
        logic [3:0] seq;
        seq = 4'b0001;        // sent seq[0] first: 1,0,0,0
        dout_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_bit(seq[i], 1'b0);
            if (i < 3) step();   // idle gap with sin_en low
        end
        checks++; if (valid1 !== 1'b1) begin failures++; $display("FAIL msb_valid got=%b exp=1", valid1); end
        checks++; if (dout1 !== 4'h8) begin failures++; $display("FAIL msb_dout got=%h exp=8", dout1); end
        checks++; if (dout0 !== 4'h1) begin failures++; $display("FAIL msb_lsb_ref_dout got=%h exp=1", dout0); end
    endtask

    task automatic test_overrun();
        logic [3:0] w;
        dout_ready = 1'b0;
        do_reset();
        w = 4'hA;
        for (int i = 0; i < 4; i++) send_bit(w[i], 1'b0);
        checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL ovr_first_word got=%b exp=0", ovr0); end
        w = 4'h5;
        for (int i = 0; i < 4; i++) send_bit(w[i], 1'b0);
        checks++; if (dout0 !== 4'hA) begin failures++; $display("FAIL ovr_dout_held got=%h exp=a", dout0); end
        checks++; if (valid0 !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", valid0); end
        checks++; if (ovr0 !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", ovr0); end
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL ovr_drain_valid got=%b exp=0", valid0); end
        checks++; if (ovr0 !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", ovr0); end
    endtask

    task automatic test_sof_and_clr();
        logic [3:0] w;
        dout_ready = 1'b1;
        do_reset();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        w = 4'hE;             // bits 0,1,1,1 with sof on the first
        for (int i = 0; i < 4; i++) send_bit(w[i], i == 0);
        checks++; if (valid0 !== 1'b1 || dout0 !== 4'hE) begin failures++; $display("FAIL sof_word got dout=%h valid=%b exp dout=e valid=1", dout0, valid0); end
        checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL sof_overrun got=%b exp=0", ovr0); end
        step();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL clr_pre_busy got=%b exp=1", busy0); end
        do_reset();
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", busy0); end
        w = 4'hC;
        for (int i = 0; i < 4; i++) send_bit(w[i], 1'b0);
        checks++; if (valid0 !== 1'b1 || dout0 !== 4'hC) begin failures++; $display("FAIL clr_clean_word got dout=%h valid=%b exp dout=c valid=1", dout0, valid0); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] w;
        dout_ready = 1'b0;
        do_reset();
        w = 4'h3;
        for (int i = 0; i < 4; i++) send_bit(w[i], 1'b0);
        checks++; if (valid0 !== 1'b1 || dout0 !== 4'h3) begin failures++; $display("FAIL b2b_first got dout=%h valid=%b exp dout=3 valid=1", dout0, valid0); end
        w = 4'h6;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dout_ready = 1'b1;
            send_bit(w[i], 1'b0);
        end
        checks++; if (valid0 !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", valid0); end
        checks++; if (dout0 !== 4'h6) begin failures++; $display("FAIL b2b_dout got=%h exp=6", dout0); end
        checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", ovr0); end
        step();
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", valid0); end
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        logic [4:0] f;
        dout_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            f = (k == 0) ? 5'b0_0011 : 5'b1_0011;  // bit4 = parity bit
            for (int i = 0; i < 5; i++) begin
                send_bit(f[i], 1'b0);
                if (i == 3) begin
                    checks++;
                    if (valid0 !== 1'b0) begin failures++; $display("FAIL par%0d_early_valid got=%b exp=0", k, valid0); end
                end
            end
            checks++; if (valid0 !== 1'b1) begin failures++; $display("FAIL par%0d_valid got=%b exp=1", k, valid0); end
            checks++; if (dout0 !== 4'h3) begin failures++; $display("FAIL par%0d_dout got=%h exp=3", k, dout0); end
            checks++; if (perr0 !== f[4]) begin failures++; $display("FAIL par%0d_err got=%b exp=%b", k, perr0, f[4]); end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SIPO_PARITY_EN
        test_parity();
`else
        test_lsb_word();
        test_msb_gaps();
        test_overrun();
        test_sof_and_clr();
        test_back_to_back();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
